fetch_stage: RTL and testbench

//   Instruction-fetch (F) stage of the 5-stage pipeline. Owns the program counter and drives
//   the byte address into the combinational instruction memory. Latches the returned word,
//   its PC and PC+4 into the IF/ID pipeline register consumed by decode.

---
 rtl/fetch_stage_pkg.sv | 33 +++
 rtl/fetch_stage_if_id_reg.sv | 52 +++++
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared definitions for the instruction-fetch stage and the pipeline
//   registers that follow it: datapath width, instruction size, the canonical
//   NOP used for bubbles, the IF/ID register payload and the next-PC select.
// ----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

    typedef enum logic [1:0] {
        PC_ADVANCE  = 2'd0,
        PC_HOLD     = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
//   Generic pipeline register carrying an instruction, its PC, PC+4 and a
//   valid bit. When enabled it either loads the incoming payload or, if
//   flush is also set, loads a NOP bubble (valid=0, pc/pc4=0). When not
//   enabled it holds. Flush has no effect while the register is held.
// Ports
//   clk    in   pipeline clock
//   rst    in   asynchronous active-high reset (loads the bubble)
//   en     in   update enable
//   flush  in   replace the incoming payload with a bubble
//   d      in   incoming payload
//   q      out  registered payload
// ----------------------------------------------------------------------------
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t bubble;
    ifid_t reg_d;
    ifid_t reg_q;

    always_comb begin
        bubble       = '0;
        bubble.instr = NOP_INSTR;
    end

    always_comb begin
        reg_d = reg_q;
        if (en) begin
            reg_d = flush ? bubble : d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q <= bubble;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the PC, presents it to a combinational
//   instruction memory and latches the returned word, its PC and PC+4 into
//   the IF/ID register. Supports decode stalls and EX-stage redirects (which
//   flush the wrong-path fetch), flags misaligned redirect targets and
//   out-of-range fetches (both sticky) and counts valid fetches.
// Parameters
//   RESET_PC    PC loaded on reset (word-aligned byte address)
//   IMEM_DEPTH  instruction memory size in words; PC[31:2] >= depth is out of range
// Ports
//   clk, rst        clock / asynchronous active-high reset
//   stall           hold PC, IF/ID and counter
//   redirect        load redirect_pc (wins over stall), flush IF/ID
//   redirect_pc     redirect target byte address
//   imem_addr       byte address to instruction memory (= PC)
//   imem_rd         instruction word for imem_addr
//   ifid_instr      registered instruction
//   ifid_pc         registered PC of ifid_instr
//   ifid_pc4        registered PC+4 of ifid_instr
//   ifid_valid      1 = real instruction, 0 = bubble
//   misalign_err    sticky: redirect target had nonzero low bits
//   oob_err         sticky: fetch attempted beyond IMEM_DEPTH
//   fetch_count     number of valid instructions latched (wraps)
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        misalign_err,
    output logic        oob_err,
    output logic [31:0] fetch_count
);

    localparam logic [XLEN-3:0] DEPTH_WORDS = (XLEN-2)'(IMEM_DEPTH);

    logic [XLEN-1:0] pc_d,          pc_q;
    logic            misalign_d,    misalign_q;
    logic            oob_d,         oob_q;
    logic [31:0]     fetch_count_d, fetch_count_q;

    pc_sel_e         pc_sel;
    logic [XLEN-1:0] pc_plus4;
    logic            pc_oob;
    logic            advance;
    logic            fetch_good;
    logic            ifid_en;
    logic            ifid_flush;
    ifid_t           ifid_in;
    ifid_t           ifid_out;

    assign pc_plus4  = pc_q + XLEN'(INSTR_BYTES);
    assign pc_oob    = (pc_q[XLEN-1:2] >= DEPTH_WORDS);
    assign imem_addr = pc_q;

    // Priority: redirect > stall > advance.
    always_comb begin
        pc_sel = PC_ADVANCE;
        if (redirect) begin
            pc_sel = PC_REDIRECT;
        end else if (stall) begin
            pc_sel = PC_HOLD;
        end
    end

    always_comb begin
        advance    = (pc_sel == PC_ADVANCE);
        fetch_good = advance && !pc_oob;
        ifid_en    = !stall || redirect;
        ifid_flush = redirect || pc_oob;
    end

    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel)
            PC_REDIRECT: pc_d = word_align(redirect_pc);
            PC_HOLD:     pc_d = pc_q;
            default:     pc_d = pc_plus4;
        endcase
    end

    always_comb begin
        misalign_d    = misalign_q | (redirect && (redirect_pc[1:0] != 2'b00));
        oob_d         = oob_q | (advance && pc_oob);
        fetch_count_d = fetch_count_q + {31'b0, fetch_good};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            misalign_q    <= 1'b0;
            oob_q         <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            misalign_q    <= misalign_d;
            oob_q         <= oob_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        ifid_in.instr = imem_rd;
        ifid_in.pc    = pc_q;
        ifid_in.pc4   = pc_plus4;
        ifid_in.valid = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .en    (ifid_en),
        .flush (ifid_flush),
        .d     (ifid_in),
        .q     (ifid_out)
    );

    assign ifid_instr   = ifid_out.instr;
    assign ifid_pc      = ifid_out.pc;
    assign ifid_pc4     = ifid_out.pc4;
    assign ifid_valid   = ifid_out.valid;
    assign misalign_err = misalign_q;
    assign oob_err      = oob_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. The instruction memory returns
//   32'hA000_0000 + word_index for in-range addresses so expected words are
//   easy to write down by hand.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        misalign_err;
    logic        oob_err;
    logic [31:0] fetch_count;

    int total;
    int bad;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .misalign_err (misalign_err),
        .oob_err      (oob_err),
        .fetch_count  (fetch_count)
    );

    assign imem_rd = (imem_addr[31:12] == 20'h0) ? (32'hA000_0000 | {20'h0, imem_addr[11:2]})
                                                 : 32'hDEAD_BEEF;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst = 1'b1;
        tick();
        total++; if (ifid_instr !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr, 32'h13); end
        total++; if (ifid_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", ifid_pc); end
        total++; if (ifid_pc4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", ifid_pc4); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
        total++; if ({misalign_err, oob_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {misalign_err, oob_err}); end
        total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (ifid_pc !== 32'(4 * k)) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, ifid_pc, 32'(4 * k)); end
            total++; if (ifid_pc4 !== 32'(4 * k + 4)) begin bad++; $display("FAIL seq_pc4[%0d] got=%h exp=%h", k, ifid_pc4, 32'(4 * k + 4)); end
            total++; if (ifid_instr !== 32'hA000_0000 + 32'(k)) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", k, ifid_instr, 32'hA000_0000 + 32'(k)); end
            total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", k, ifid_valid); end
        end
        total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL seq_count got=%0d exp=4", fetch_count); end
        total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL seq_imem_addr got=%h exp=10", imem_addr); end
    endtask

    // Fresh reset, two fetches (PC 0,4), then stall two cycles at PC 8.
    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL stall_imem_addr[%0d] got=%h exp=8", k, imem_addr); end
            total++; if (ifid_pc !== 32'h4) begin bad++; $display("FAIL stall_ifid_pc[%0d] got=%h exp=4", k, ifid_pc); end
            total++; if (ifid_instr !== 32'hA000_0001) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=a0000001", k, ifid_instr); end
            total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=2", k, fetch_count); end
        end
        stall = 1'b0;
        tick();
        total++; if (ifid_pc !== 32'h8) begin bad++; $display("FAIL stall_resume_pc got=%h exp=8", ifid_pc); end
        total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL stall_resume_count got=%0d exp=3", fetch_count); end
    endtask

    // PC is 0xC here; redirect with stall in the same cycle.
    task automatic test_redirect_stall();
        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        tick();
        redirect = 1'b0; stall = 1'b0;
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", ifid_valid); end
        total++; if (ifid_instr !== 32'h13) begin bad++; $display("FAIL redir_instr got=%h exp=13", ifid_instr); end
        total++; if ({ifid_pc, ifid_pc4} !== 64'h0) begin bad++; $display("FAIL redir_pcs got=%h/%h exp=0/0", ifid_pc, ifid_pc4); end
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL redir_imem_addr got=%h exp=40", imem_addr); end
        total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL redir_count got=%0d exp=3", fetch_count); end
        tick();
        total++; if (ifid_pc !== 32'h40) begin bad++; $display("FAIL redir_next_pc got=%h exp=40", ifid_pc); end
        total++; if (ifid_instr !== 32'hA000_0010) begin bad++; $display("FAIL redir_next_instr got=%h exp=a0000010", ifid_instr); end
        total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL redir_next_count got=%0d exp=4", fetch_count); end
    endtask

    task automatic test_misalign();
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL misalign_pre got=%b exp=0", misalign_err); end
        redirect = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect = 1'b0;
        total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL misalign_addr got=%h exp=20", imem_addr); end
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL misalign_set got=%b exp=1", misalign_err); end
        tick();
        tick();
        total++; if (ifid_pc !== 32'h24) begin bad++; $display("FAIL misalign_follow_pc got=%h exp=24", ifid_pc); end
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL misalign_sticky got=%b exp=1", misalign_err); end
        total++; if (fetch_count !== 32'd6) begin bad++; $display("FAIL misalign_count got=%0d exp=6", fetch_count); end
    endtask

    task automatic test_oob_and_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFC;
        tick();
        redirect = 1'b0;
        tick();
        total++; if ({ifid_valid, ifid_pc} !== {1'b1, 32'hFFC}) begin bad++; $display("FAIL oob_last_good got=%b/%h exp=1/ffc", ifid_valid, ifid_pc); end
        total++; if (ifid_instr !== 32'hA000_03FF) begin bad++; $display("FAIL oob_last_instr got=%h exp=a00003ff", ifid_instr); end
        total++; if (oob_err !== 1'b0) begin bad++; $display("FAIL oob_pre got=%b exp=0", oob_err); end
        total++; if (fetch_count !== 32'd7) begin bad++; $display("FAIL oob_pre_count got=%0d exp=7", fetch_count); end
        tick();
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL oob_valid got=%b exp=0", ifid_valid); end
        total++; if (ifid_instr !== 32'h13) begin bad++; $display("FAIL oob_instr got=%h exp=13", ifid_instr); end
        total++; if (oob_err !== 1'b1) begin bad++; $display("FAIL oob_set got=%b exp=1", oob_err); end
        total++; if (fetch_count !== 32'd7) begin bad++; $display("FAIL oob_count got=%0d exp=7", fetch_count); end
        total++; if (imem_addr !== 32'h1004) begin bad++; $display("FAIL oob_advance got=%h exp=1004", imem_addr); end
        // Top of the address space: out of range, and PC wraps to 0.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL wrap_valid got=%b exp=0", ifid_valid); end
        tick();
        total++; if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'h0, 32'hA000_0000}) begin bad++; $display("FAIL wrap_fetch got=%b/%h/%h exp=1/0/a0000000", ifid_valid, ifid_pc, ifid_instr); end
        total++; if ({oob_err, misalign_err} !== 2'b11) begin bad++; $display("FAIL flags_sticky got=%b exp=11", {oob_err, misalign_err}); end
        total++; if (fetch_count !== 32'd8) begin bad++; $display("FAIL wrap_count got=%0d exp=8", fetch_count); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++; if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {1'b0, 32'h13, 32'h0, 32'h0}) begin bad++; $display("FAIL async_ifid got=%b/%h/%h/%h exp=0/13/0/0", ifid_valid, ifid_instr, ifid_pc, ifid_pc4); end
        total++; if ({misalign_err, oob_err} !== 2'b00) begin bad++; $display("FAIL async_flags got=%b exp=00", {misalign_err, oob_err}); end
        total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL async_count got=%0d exp=0", fetch_count); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL async_addr got=%h exp=0", imem_addr); end
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        tick();
        total++; if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'h0, 32'hA000_0000}) begin bad++; $display("FAIL async_first got=%b/%h/%h exp=1/0/a0000000", ifid_valid, ifid_pc, ifid_instr); end
        total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL async_first_count got=%0d exp=1", fetch_count); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_oob_and_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
